// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port (I-cache / D-cache) main-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic PORT_ICACHE = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

    localparam int LINE_BITS              = 512;
    localparam int ADDR_BITS              = 32;
    localparam int DATA_BITS              = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and main-memory signal bundle; slave is the arbiter's view, master the environment's.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [ADDR_BITS-1:0] req_addr0, req_addr1;
    logic [DATA_BITS-1:0] req_wdata0, req_wdata1;
    logic                 req_read0, req_read1;
    logic                 req_write0, req_write1;
    logic                 req_ready0, req_ready1;
    logic                 req_err0, req_err1;
    logic [LINE_BITS-1:0] req_rdata;

    logic [ADDR_BITS-1:0] main_mem_addr;
    logic [DATA_BITS-1:0] main_mem_data_out;
    logic                 main_mem_read_req, main_mem_write_req;
    logic [LINE_BITS-1:0] main_mem_data_in;
    logic                 main_mem_ready;

    modport slave (
        input  req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_read0, req_read1, req_write0, req_write1,
               main_mem_data_in, main_mem_ready,
        output req_ready0, req_ready1, req_err0, req_err1, req_rdata,
               main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req
    );

    modport master (
        output req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_read0, req_read1, req_write0, req_write1,
               main_mem_data_in, main_mem_ready,
        input  req_ready0, req_ready1, req_err0, req_err1, req_rdata,
               main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Saturating BUSY-cycle counter; expired flags the cycle in which the transaction runs out of time.
module mem_arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the stalled cycles already elapsed, so this fires during the TIMEOUT_CYCLES-th one
    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting main memory to the I-cache or D-cache port, one line transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int N_PORTS        = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int PORT_W = $clog2(N_PORTS);

    state_t               state, state_nxt;
    logic [PORT_W-1:0]    grant_id, last_grant, grant_sel;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 read_q, write_q;
    logic                 pend0, pend1, sel_write;
    logic                 grant, done, expired, wd_enable;

    assign pend0 = bus.req_read0 | bus.req_write0;
    assign pend1 = bus.req_read1 | bus.req_write1;

    always_comb begin
        grant_sel = PORT_ICACHE;
        if (pend0 && pend1) begin
            grant_sel = ~last_grant;
        end else if (pend1) begin
            grant_sel = PORT_DCACHE;
        end
    end

    // write beats read on the same port so a dirty line is written back before the refill
    assign sel_write = (grant_sel == PORT_DCACHE) ? bus.req_write1 : bus.req_write0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.main_mem_ready || expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= PORT_ICACHE;
            last_grant <= PORT_DCACHE;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else if (grant) begin
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            addr_q     <= (grant_sel == PORT_DCACHE) ? bus.req_addr1  : bus.req_addr0;
            wdata_q    <= (grant_sel == PORT_DCACHE) ? bus.req_wdata1 : bus.req_wdata0;
            read_q     <= ~sel_write;
            write_q    <= sel_write;
        end else if (done) begin
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end
    end

    assign wd_enable = (state == BUSY) && !bus.main_mem_ready;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (wd_enable),
        .expired(expired)
    );

    assign bus.main_mem_addr      = addr_q;
    assign bus.main_mem_data_out  = wdata_q;
    assign bus.main_mem_read_req  = read_q;
    assign bus.main_mem_write_req = write_q;
    assign bus.req_rdata          = bus.main_mem_data_in;

    assign bus.req_ready0 = (state == BUSY) && bus.main_mem_ready && (grant_id == PORT_ICACHE);
    assign bus.req_ready1 = (state == BUSY) && bus.main_mem_ready && (grant_id == PORT_DCACHE);
    assign bus.req_err0   = expired && (grant_id == PORT_ICACHE);
    assign bus.req_err1   = expired && (grant_id == PORT_DCACHE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .N_PORTS       (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          active;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wr;
        int          age;
    } txn_t;

    txn_t cur       = '{active: 1'b0, port: 0, addr: '0, wdata: '0, wr: 1'b0, age: 0};
    int   last_port = 1;
    int   model_grants[$];
    int   dut_ready0_cnt = 0;
    int   dut_ready1_cnt = 0;
    int   dut_err_cnt    = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit want(input int p);
        if (p == 1) return bus.req_read1 || bus.req_write1;
        return bus.req_read0 || bus.req_write0;
    endfunction

    function automatic int pick(input int last);
        if (want(0) && want(1)) return 1 - last;
        return want(1) ? 1 : 0;
    endfunction

    function automatic txn_t open_txn(input int p);
        txn_t t;
        t.active = 1'b1;
        t.port   = p;
        t.age    = 0;
        t.addr   = (p == 1) ? bus.req_addr1  : bus.req_addr0;
        t.wdata  = (p == 1) ? bus.req_wdata1 : bus.req_wdata0;
        t.wr     = (p == 1) ? bus.req_write1 : bus.req_write0;
        return t;
    endfunction

    // Reference model: one open transaction at most, closed by memory ready or by its TO-th stalled cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.active <= 1'b0;
            last_port  <= 1;
        end else if (!cur.active) begin
            if (want(0) || want(1)) begin
                cur       <= open_txn(pick(last_port));
                last_port <= pick(last_port);
                model_grants.push_back(pick(last_port));
            end
        end else if (bus.main_mem_ready || (cur.age + 1 == TO)) begin
            cur.active <= 1'b0;
        end else begin
            cur.age <= cur.age + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ready0", bus.req_ready0, cur.active && bus.main_mem_ready && cur.port == 0);
            check("ready1", bus.req_ready1, cur.active && bus.main_mem_ready && cur.port == 1);
            check("err0", bus.req_err0,
                  cur.active && !bus.main_mem_ready && (cur.age + 1 == TO) && cur.port == 0);
            check("err1", bus.req_err1,
                  cur.active && !bus.main_mem_ready && (cur.age + 1 == TO) && cur.port == 1);
            check("mm_read_req", bus.main_mem_read_req, cur.active && !cur.wr);
            check("mm_write_req", bus.main_mem_write_req, cur.active && cur.wr);
            check("rdata", bus.req_rdata, bus.main_mem_data_in);
            if (cur.active) begin
                check("mm_addr", bus.main_mem_addr, cur.addr);
                check("mm_data_out", bus.main_mem_data_out, cur.wdata);
            end
            if (bus.req_ready0 === 1'b1) dut_ready0_cnt++;
            if (bus.req_ready1 === 1'b1) dut_ready1_cnt++;
            if ((bus.req_err0 === 1'b1) || (bus.req_err1 === 1'b1)) dut_err_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] line_a;
        line_a = {16{32'h00001040}};

        bus.req_addr0  = '0;  bus.req_addr1  = '0;
        bus.req_wdata0 = '0;  bus.req_wdata1 = '0;
        bus.req_read0  = 1'b0; bus.req_read1  = 1'b0;
        bus.req_write0 = 1'b0; bus.req_write1 = 1'b0;
        bus.main_mem_data_in = {16{32'h0BADF00D}};
        bus.main_mem_ready   = 1'b0;

        step();
        check("rst_read_req", bus.main_mem_read_req, 1'b0);
        check("rst_write_req", bus.main_mem_write_req, 1'b0);
        check("rst_addr", bus.main_mem_addr, 32'h0);
        check("rst_data_out", bus.main_mem_data_out, 32'h0);
        check("rst_ready", {bus.req_ready1, bus.req_ready0}, 2'b00);
        check("rst_err", {bus.req_err1, bus.req_err0}, 2'b00);
        rst = 1'b0;

        // Contention right after reset: port 0, then port 1, then port 0 again
        bus.req_read0 = 1'b1; bus.req_addr0 = 32'h00000100;
        bus.req_read1 = 1'b1; bus.req_addr1 = 32'h00000200;
        step();
        check("rr1_addr", bus.main_mem_addr, 32'h00000100);
        bus.main_mem_ready = 1'b1;
        #1;
        check("rr1_ready0", bus.req_ready0, 1'b1);
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read0 = 1'b0;
        check("rr_gap_idle", bus.main_mem_read_req, 1'b0);
        step();
        check("rr2_addr", bus.main_mem_addr, 32'h00000200);
        bus.main_mem_ready = 1'b1;
        #1;
        check("rr2_ready1", bus.req_ready1, 1'b1);
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read1 = 1'b0;
        bus.req_read0 = 1'b1; bus.req_addr0 = 32'h00000300;
        bus.req_read1 = 1'b1; bus.req_addr1 = 32'h00000400;
        step();
        check("rr3_addr", bus.main_mem_addr, 32'h00000300);
        bus.main_mem_ready = 1'b1;
        #1;
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read0 = 1'b0;
        bus.req_read1 = 1'b0;
        check("model_grant_n", model_grants.size(), 3);
        if (model_grants.size() == 3) begin
            check("model_grant0", model_grants[0], 0);
            check("model_grant1", model_grants[1], 1);
            check("model_grant2", model_grants[2], 0);
        end
        check("rr_ready0_cnt", dut_ready0_cnt, 2);
        check("rr_ready1_cnt", dut_ready1_cnt, 1);

        // Port 0 line read, memory answers in the 5th BUSY cycle
        bus.req_read0 = 1'b1; bus.req_addr0 = 32'h00001040;
        step();
        check("a_addr", bus.main_mem_addr, 32'h00001040);
        check("a_read_req", bus.main_mem_read_req, 1'b1);
        check("a_write_req", bus.main_mem_write_req, 1'b0);
        repeat (4) step();
        bus.main_mem_ready   = 1'b1;
        bus.main_mem_data_in = line_a;
        #1;
        check("a_ready0", bus.req_ready0, 1'b1);
        check("a_ready1", bus.req_ready1, 1'b0);
        check("a_rdata", bus.req_rdata, line_a);
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read0 = 1'b0;
        check("a_idle_after", bus.main_mem_read_req, 1'b0);

        // Port 1 read+write: write wins; later request changes and a dropped request are ignored
        bus.req_read1 = 1'b1; bus.req_write1 = 1'b1;
        bus.req_addr1 = 32'h00002000; bus.req_wdata1 = 32'hDEADBEEF;
        step();
        check("c_write_req", bus.main_mem_write_req, 1'b1);
        check("c_read_req", bus.main_mem_read_req, 1'b0);
        check("c_data_out", bus.main_mem_data_out, 32'hDEADBEEF);
        bus.req_write1 = 1'b0;
        bus.req_addr1 = 32'hFFFF0000; bus.req_wdata1 = 32'h12345678;
        step();
        check("c_addr_held", bus.main_mem_addr, 32'h00002000);
        check("c_data_held", bus.main_mem_data_out, 32'hDEADBEEF);
        bus.req_read1 = 1'b0;
        step();
        bus.main_mem_ready = 1'b1;
        bus.main_mem_data_in = {16{32'hC0FFEE01}};
        #1;
        check("c_ready1_after_drop", bus.req_ready1, 1'b1);
        step();
        bus.main_mem_ready = 1'b0;

        // Memory ready while idle must be ignored
        bus.main_mem_ready = 1'b1;
        #1;
        check("idle_ready", {bus.req_ready1, bus.req_ready0}, 2'b00);
        step();
        check("idle_stays", {bus.main_mem_write_req, bus.main_mem_read_req}, 2'b00);
        bus.main_mem_ready = 1'b0;

        // Timeout: error in the 8th BUSY cycle, then a ready in the 8th cycle wins over the timeout
        bus.req_read0 = 1'b1; bus.req_addr0 = 32'h00003000;
        step();
        repeat (6) step();
        check("d_err_cycle7", bus.req_err0, 1'b0);
        step();
        check("d_err_cycle8", bus.req_err0, 1'b1);
        check("d_no_ready", bus.req_ready0, 1'b0);
        step();
        check("d_back_idle", bus.main_mem_read_req, 1'b0);
        step();
        repeat (7) step();
        bus.main_mem_ready = 1'b1;
        #1;
        check("d_ready_wins", bus.req_ready0, 1'b1);
        check("d_no_err", bus.req_err0, 1'b0);
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read0 = 1'b0;

        // Reset in the 2nd BUSY cycle, followed by a late memory ready
        bus.req_read0 = 1'b1; bus.req_addr0 = 32'h00004000; bus.req_wdata0 = 32'h44440000;
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        check("e_addr_zero", bus.main_mem_addr, 32'h0);
        check("e_data_zero", bus.main_mem_data_out, 32'h0);
        check("e_reqs_zero", {bus.main_mem_write_req, bus.main_mem_read_req}, 2'b00);
        bus.main_mem_ready = 1'b1;
        #1;
        check("e_no_ready", {bus.req_ready1, bus.req_ready0}, 2'b00);
        check("e_no_err", {bus.req_err1, bus.req_err0}, 2'b00);
        step();
        rst = 1'b0;
        bus.req_read0 = 1'b0;
        #1;
        check("e_late_ready", {bus.req_ready1, bus.req_ready0}, 2'b00);
        step();
        check("e_still_idle", bus.main_mem_read_req, 1'b0);
        bus.main_mem_ready = 1'b0;
        bus.req_read1 = 1'b1; bus.req_addr1 = 32'h00005000;
        step();
        check("e_first_grant", bus.main_mem_read_req, 1'b1);
        check("e_first_addr", bus.main_mem_addr, 32'h00005000);
        bus.main_mem_ready = 1'b1;
        #1;
        check("e_ready1", bus.req_ready1, 1'b1);
        step();
        bus.main_mem_ready = 1'b0;
        bus.req_read1 = 1'b0;
        step();

        check("total_ready0", dut_ready0_cnt, 4);
        check("total_ready1", dut_ready1_cnt, 3);
        check("total_err", dut_err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
